// File: rtl/sipo_shift_receiver_if.sv
// Bundles the serial link side and the parallel valid/ready side of the SIPO receiver.
// The master modport is the driver/consumer environment; the slave modport is the receiver.
interface sipo_shift_receiver_if #(parameter int WIDTH = 4);
   logic             din;
   logic             din_valid;
   logic             sync;
   logic             mode;
   logic [WIDTH-1:0] dout;
   logic             dout_valid;
   logic             dout_ready;
   logic             busy;
   logic             overflow;
   logic             frame_err;
   logic             clr_err;

   modport master (
      output din, din_valid, sync, mode, dout_ready, clr_err,
      input  dout, dout_valid, busy, overflow, frame_err
   );

   modport slave (
      input  din, din_valid, sync, mode, dout_ready, clr_err,
      output dout, dout_valid, busy, overflow, frame_err
   );
endinterface

// File: rtl/sipo_shift_receiver.sv
// Serial-in/parallel-out receiver: rebuilds WIDTH-bit words from a sync-framed bit stream
// and offers them through a one-word holding register on a valid/ready port.
module sipo_shift_receiver #(
   parameter int WIDTH = 4,
   parameter int CNT_W = $clog2(WIDTH + 1)
) (
   input logic                   clk,
   input logic                   rst_n,
   sipo_shift_receiver_if.slave  bus
);

   typedef enum logic {IDLE, SHIFT} state_t;

   localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);
   localparam logic [CNT_W-1:0] ONE  = CNT_W'(1);

   state_t           state_q, state_d;
   logic [WIDTH-1:0] sr_q, sr_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             mode_q, mode_d;
   logic [WIDTH-1:0] dout_q, dout_d;
   logic             dvalid_q, dvalid_d;
   logic             ovf_q, ovf_d;
   logic             ferr_q, ferr_d;

   logic             mode_eff;
   logic [WIDTH-1:0] base;
   logic [WIDTH-1:0] shifted;
   logic             done;
   logic             ovf_set;
   logic             ferr_set;

   always_comb begin
      state_d  = state_q;
      sr_d     = sr_q;
      cnt_d    = cnt_q;
      mode_d   = mode_q;
      dout_d   = dout_q;
      dvalid_d = dvalid_q;
      done     = 1'b0;
      ovf_set  = 1'b0;
      ferr_set = 1'b0;

      // A sync bit starts from an empty register, so bit 0 lands where the shifts expect it.
      mode_eff = bus.sync ? bus.mode : mode_q;
      base     = bus.sync ? '0 : sr_q;
      shifted  = mode_eff ? {bus.din, base[WIDTH-1:1]} : {base[WIDTH-2:0], bus.din};

      if (dvalid_q && bus.dout_ready) dvalid_d = 1'b0;

      if (bus.din_valid) begin
         if (bus.sync) begin
            if (state_q == SHIFT) ferr_set = 1'b1;
            state_d = SHIFT;
            sr_d    = shifted;
            cnt_d   = ONE;
            mode_d  = bus.mode;
         end else if (state_q == SHIFT) begin
            sr_d = shifted;
            if (cnt_q == LAST) begin
               done    = 1'b1;
               cnt_d   = '0;
               state_d = IDLE;
            end else begin
               cnt_d = cnt_q + ONE;
            end
         end
      end

      // A completion consumed on the same cycle as the pending word replaces it seamlessly.
      if (done) begin
         if (!dvalid_q || bus.dout_ready) begin
            dout_d   = shifted;
            dvalid_d = 1'b1;
         end else begin
            ovf_set = 1'b1;
         end
      end

      ovf_d  = (ovf_q  & ~bus.clr_err) | ovf_set;
      ferr_d = (ferr_q & ~bus.clr_err) | ferr_set;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= IDLE;
         sr_q     <= '0;
         cnt_q    <= '0;
         mode_q   <= 1'b1;
         dout_q   <= '0;
         dvalid_q <= 1'b0;
         ovf_q    <= 1'b0;
         ferr_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         sr_q     <= sr_d;
         cnt_q    <= cnt_d;
         mode_q   <= mode_d;
         dout_q   <= dout_d;
         dvalid_q <= dvalid_d;
         ovf_q    <= ovf_d;
         ferr_q   <= ferr_d;
      end
   end

   assign bus.dout       = dout_q;
   assign bus.dout_valid = dvalid_q;
   assign bus.busy       = (state_q == SHIFT);
   assign bus.overflow   = ovf_q;
   assign bus.frame_err  = ferr_q;

endmodule

// File: tb/tb_sipo_shift_receiver.sv
// Directed bench for sipo_shift_receiver: a per-cycle vector table plus hand-written
// sequences for overflow, simultaneous handoff, mid-word sync and reset mid-word.
module tb_sipo_shift_receiver;

   localparam int WIDTH = 4;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int   errors = 0;
   int   checks = 0;

   always #5 clk = ~clk;

   sipo_shift_receiver_if #(.WIDTH(WIDTH)) bus ();

   sipo_shift_receiver #(.WIDTH(WIDTH)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus.slave)
   );

   typedef struct {
      logic       din;
      logic       dv;
      logic       sy;
      logic       md;
      logic       rd;
      logic       clr;
      logic [3:0] e_dout;
      logic       e_dval;
      logic       e_busy;
      logic       e_ovf;
      logic       e_ferr;
   } vec_t;

   vec_t vecs[13];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic check_all(input string tag, input logic [3:0] d, input logic v,
                            input logic b, input logic o, input logic f);
      check({tag, ".dout"},       32'(bus.dout),       32'(d));
      check({tag, ".dout_valid"}, 32'(bus.dout_valid), 32'(v));
      check({tag, ".busy"},       32'(bus.busy),       32'(b));
      check({tag, ".overflow"},   32'(bus.overflow),   32'(o));
      check({tag, ".frame_err"},  32'(bus.frame_err),  32'(f));
   endtask

   // Drive one cycle of inputs, then sample outputs 1 time unit after the rising edge.
   task automatic step(input logic din, input logic dv, input logic sy, input logic md,
                       input logic rd, input logic clr);
      bus.din        = din;
      bus.din_valid  = dv;
      bus.sync       = sy;
      bus.mode       = md;
      bus.dout_ready = rd;
      bus.clr_err    = clr;
      @(posedge clk);
      #1;
   endtask

   task automatic send_word(input logic [3:0] w, input logic m, input logic rdy_last);
      for (int i = 0; i < WIDTH; i++)
         step(m ? w[i] : w[WIDTH-1-i], 1'b1, i == 0, m, (i == WIDTH-1) ? rdy_last : 1'b0, 1'b0);
   endtask

   initial begin
      //             din dv sy md rd clr   dout  val busy ovf ferr
      vecs[0]  = '{1'b1,1'b1,1'b1,1'b1,1'b0,1'b0, 4'h0,1'b0,1'b1,1'b0,1'b0};
      vecs[1]  = '{1'b0,1'b1,1'b0,1'b1,1'b0,1'b0, 4'h0,1'b0,1'b1,1'b0,1'b0};
      vecs[2]  = '{1'b1,1'b0,1'b1,1'b0,1'b0,1'b0, 4'h0,1'b0,1'b1,1'b0,1'b0};
      vecs[3]  = '{1'b0,1'b1,1'b0,1'b0,1'b0,1'b0, 4'h0,1'b0,1'b1,1'b0,1'b0};
      vecs[4]  = '{1'b0,1'b1,1'b0,1'b0,1'b0,1'b0, 4'h1,1'b1,1'b0,1'b0,1'b0};
      vecs[5]  = '{1'b1,1'b1,1'b0,1'b0,1'b1,1'b0, 4'h1,1'b0,1'b0,1'b0,1'b0};
      vecs[6]  = '{1'b1,1'b1,1'b1,1'b0,1'b0,1'b0, 4'h1,1'b0,1'b1,1'b0,1'b0};
      vecs[7]  = '{1'b0,1'b1,1'b0,1'b1,1'b0,1'b0, 4'h1,1'b0,1'b1,1'b0,1'b0};
      vecs[8]  = '{1'b1,1'b1,1'b0,1'b1,1'b0,1'b0, 4'h1,1'b0,1'b1,1'b0,1'b0};
      vecs[9]  = '{1'b1,1'b1,1'b0,1'b1,1'b0,1'b0, 4'hB,1'b1,1'b0,1'b0,1'b0};
      vecs[10] = '{1'b0,1'b0,1'b0,1'b0,1'b0,1'b0, 4'hB,1'b1,1'b0,1'b0,1'b0};
      vecs[11] = '{1'b0,1'b0,1'b0,1'b0,1'b0,1'b0, 4'hB,1'b1,1'b0,1'b0,1'b0};
      vecs[12] = '{1'b0,1'b0,1'b0,1'b0,1'b1,1'b0, 4'hB,1'b0,1'b0,1'b0,1'b0};

      bus.din = 1'b0; bus.din_valid = 1'b0; bus.sync = 1'b0; bus.mode = 1'b0;
      bus.dout_ready = 1'b0; bus.clr_err = 1'b0;

      repeat (2) @(posedge clk);
      #1;
      check_all("reset", 4'h0, 1'b0, 1'b0, 1'b0, 1'b0);
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;

      // LSB-first 4'h1 with a din_valid gap, then ignored non-sync bit; MSB-first 4'hB held.
      for (int i = 0; i < 13; i++) begin
         step(vecs[i].din, vecs[i].dv, vecs[i].sy, vecs[i].md, vecs[i].rd, vecs[i].clr);
         check_all($sformatf("vec%0d", i), vecs[i].e_dout, vecs[i].e_dval,
                   vecs[i].e_busy, vecs[i].e_ovf, vecs[i].e_ferr);
      end

      // Overflow: 4'h5 arrives while 4'h3 is still pending and is dropped.
      send_word(4'h3, 1'b1, 1'b0);
      check_all("ovf.first", 4'h3, 1'b1, 1'b0, 1'b0, 1'b0);
      send_word(4'h5, 1'b1, 1'b0);
      check_all("ovf.drop", 4'h3, 1'b1, 1'b0, 1'b1, 1'b0);
      step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
      check_all("ovf.consume", 4'h3, 1'b0, 1'b0, 1'b1, 1'b0);
      step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      check_all("ovf.no5", 4'h3, 1'b0, 1'b0, 1'b1, 1'b0);
      step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
      check_all("ovf.clr", 4'h3, 1'b0, 1'b0, 1'b0, 1'b0);

      // Simultaneous: pending 4'h3 consumed on the cycle 4'hA completes.
      send_word(4'h3, 1'b1, 1'b0);
      send_word(4'hA, 1'b1, 1'b1);
      check_all("simul", 4'hA, 1'b1, 1'b0, 1'b0, 1'b0);
      step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
      check_all("simul.consume", 4'hA, 1'b0, 1'b0, 1'b0, 1'b0);

      // Mid-word sync on the 3rd bit restarts the word; LSB bits 0,1,0,1 -> 4'hA.
      step(1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
      step(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
      step(1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
      check_all("msync.err", 4'hA, 1'b0, 1'b1, 1'b0, 1'b1);
      step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
      step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
      check_all("msync.mid", 4'hA, 1'b0, 1'b1, 1'b0, 1'b1);
      step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
      check_all("msync.word", 4'hA, 1'b1, 1'b0, 1'b0, 1'b1);
      step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
      check_all("msync.clr", 4'hA, 1'b0, 1'b0, 1'b0, 1'b0);

      // Set wins over clear when a mid-word sync coincides with clr_err.
      step(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
      step(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
      check_all("setwins", 4'hA, 1'b0, 1'b1, 1'b0, 1'b1);
      step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
      step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
      step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
      check_all("setwins.word", 4'hC, 1'b1, 1'b0, 1'b0, 1'b0);

      // Reset mid-word: async clear is visible before the next edge.
      step(1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
      step(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
      #2;
      rst_n = 1'b0;
      #1;
      check_all("rst.async", 4'h0, 1'b0, 1'b0, 1'b0, 1'b0);
      bus.din_valid = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      check_all("rst.idle", 4'h0, 1'b0, 1'b0, 1'b0, 1'b0);
      step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
      check_all("rst.nosync", 4'h0, 1'b0, 1'b0, 1'b0, 1'b0);
      send_word(4'h6, 1'b0, 1'b0);
      check_all("rst.word", 4'h6, 1'b1, 1'b0, 1'b0, 1'b0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
